// File: rtl/sd_dma_pkg.sv
// Shared types and constants for the SD Wishbone DMA master.
package sd_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FETCH,
    ST_BUS,
    ST_POST
  } state_t;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

endpackage

// File: rtl/sd_wb_dma_master.sv
// Wishbone classic master moving 32-bit words between memory and the SD data FIFOs,
// one single beat at a time, throttled by the FIFO full/empty flags.
module sd_wb_dma_master
  import sd_dma_pkg::*;
#(
  parameter int LEN_W = 9
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic [31:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic [31:0]      m_wb_adr_o,
  output logic [31:0]      m_wb_dat_o,
  input  logic [31:0]      m_wb_dat_i,
  output logic [3:0]       m_wb_sel_o,
  output logic             m_wb_we_o,
  output logic             m_wb_cyc_o,
  output logic             m_wb_stb_o,
  input  logic             m_wb_ack_i,
  input  logic             m_wb_err_i,
  output logic             tx_fifo_we_o,
  output logic [31:0]      tx_fifo_dat_o,
  input  logic             tx_fifo_full_i,
  output logic             rx_fifo_rd_o,
  input  logic [31:0]      rx_fifo_dat_i,
  input  logic             rx_fifo_empty_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_o,
  output state_t           state_o
);

  state_t           state, state_next;
  logic             dir_q;
  logic [31:0]      adr_q, wdat_q, tx_dat_q;
  logic [LEN_W-1:0] len_q, words_q;
  logic             abort_q, done_q, err_q;
  logic             beat_ok, beat_err, last_word, stop;

  // Handshake: stb is a request held with a stable address until the slave answers
  // with ack or err in the same cycle; err takes priority over ack.
  always_comb begin
    beat_err   = (state == ST_BUS) && m_wb_err_i;
    beat_ok    = (state == ST_BUS) && m_wb_ack_i && !m_wb_err_i;
    last_word  = (words_q + {{(LEN_W-1){1'b0}}, 1'b1}) == len_q;
    stop       = abort_i || abort_q;
    state_next = state;
    case (state)
      ST_IDLE: begin
        // A read with FIFO room skips WAIT so the first strobe follows start directly.
        if (start_i && (len_i != '0))
          state_next = (!dir_i && !tx_fifo_full_i) ? ST_BUS : ST_WAIT;
      end
      ST_WAIT: begin
        if (abort_i)                        state_next = ST_IDLE;
        else if (dir_q && !rx_fifo_empty_i) state_next = ST_FETCH;
        else if (!dir_q && !tx_fifo_full_i) state_next = ST_BUS;
      end
      ST_FETCH: state_next = abort_i ? ST_IDLE : ST_BUS;
      ST_BUS: begin
        if (beat_err)     state_next = ST_IDLE;
        else if (beat_ok) state_next = ST_POST;
      end
      ST_POST: state_next = (stop || last_word) ? ST_IDLE : ST_WAIT;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state    <= ST_IDLE;
      dir_q    <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
      tx_dat_q <= '0;
      len_q    <= '0;
      words_q  <= '0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            dir_q   <= dir_i;
            adr_q   <= addr_i & ~32'h3;
            len_q   <= len_i;
            words_q <= '0;
            abort_q <= 1'b0;
            if (len_i == '0) done_q <= 1'b1;
          end
        end
        ST_FETCH: wdat_q <= rx_fifo_dat_i;
        ST_BUS: begin
          // Abort cannot cut a beat short; remember it so POST ends the transfer.
          if (abort_i)               abort_q  <= 1'b1;
          if (beat_ok && !dir_q)     tx_dat_q <= m_wb_dat_i;
          if (beat_err)              err_q    <= 1'b1;
        end
        ST_POST: begin
          adr_q   <= adr_q + ADDR_STEP;
          words_q <= words_q + {{(LEN_W-1){1'b0}}, 1'b1};
          if (last_word && !stop) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign m_wb_cyc_o    = (state != ST_IDLE);
  assign m_wb_stb_o    = (state == ST_BUS);
  assign m_wb_we_o     = m_wb_cyc_o && dir_q;
  assign m_wb_sel_o    = m_wb_cyc_o ? WB_SEL_ALL : 4'h0;
  assign m_wb_adr_o    = adr_q;
  assign m_wb_dat_o    = wdat_q;
  assign tx_fifo_we_o  = (state == ST_POST) && !dir_q;
  assign tx_fifo_dat_o = tx_dat_q;
  assign rx_fifo_rd_o  = (state == ST_WAIT) && dir_q && !rx_fifo_empty_i && !abort_i;
  assign busy_o        = (state != ST_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign words_o       = words_q;
  assign state_o       = state;

endmodule

// File: tb/tb_sd_wb_dma_master.sv
// Bench for sd_wb_dma_master: memory/slave model, FIFO models, scoreboard queues
// for bus beats and TX FIFO writes, one task per scenario.
module tb_sd_wb_dma_master;
  import sd_dma_pkg::*;

  localparam int LEN_W = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0, dir_i = 1'b0, abort_i = 1'b0;
  logic [31:0]      addr_i = '0;
  logic [LEN_W-1:0] len_i = '0;
  logic [31:0]      m_wb_adr_o, m_wb_dat_o, m_wb_dat_i;
  logic [3:0]       m_wb_sel_o;
  logic             m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_ack_i, m_wb_err_i;
  logic             tx_fifo_we_o, rx_fifo_rd_o, rx_fifo_empty_i;
  logic [31:0]      tx_fifo_dat_o;
  logic             tx_full = 1'b0;
  logic [31:0]      rx_dat = '0;
  logic             busy_o, done_o, err_o;
  logic [LEN_W-1:0] words_o;
  state_t           dbg_state;
  logic [116:0]     all_out;

  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0, rd_cnt = 0, cyc_cnt = 0;
  int wait_states = 0, err_beat = -1, wcnt = 0, beat_idx = 0;
  int rx_pushes = 0, rx_pops = 0;
  logic [31:0] rx_mem [64];
  logic [32:0] exp_adr_q[$];
  logic [31:0] exp_wdat_q[$];
  logic [31:0] exp_tx_q[$];
  logic [32:0] mon_e;
  logic [31:0] mon_d;
  logic        hit;

  sd_wb_dma_master #(.LEN_W(LEN_W)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start_i), .dir_i(dir_i),
    .addr_i(addr_i), .len_i(len_i), .abort_i(abort_i),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i),
    .m_wb_sel_o(m_wb_sel_o), .m_wb_we_o(m_wb_we_o), .m_wb_cyc_o(m_wb_cyc_o),
    .m_wb_stb_o(m_wb_stb_o), .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i),
    .tx_fifo_we_o(tx_fifo_we_o), .tx_fifo_dat_o(tx_fifo_dat_o), .tx_fifo_full_i(tx_full),
    .rx_fifo_rd_o(rx_fifo_rd_o), .rx_fifo_dat_i(rx_dat), .rx_fifo_empty_i(rx_fifo_empty_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o), .state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign all_out = {m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o,
                    tx_fifo_we_o, tx_fifo_dat_o, rx_fifo_rd_o, busy_o, done_o, err_o, words_o};

  // slave and FIFO models
  assign hit             = m_wb_cyc_o && m_wb_stb_o && (wcnt >= wait_states);
  assign m_wb_err_i      = hit && (beat_idx == err_beat);
  assign m_wb_ack_i      = hit && (beat_idx != err_beat);
  assign m_wb_dat_i      = mem_f(m_wb_adr_o);
  assign rx_fifo_empty_i = (rx_pushes == rx_pops);

  always @(posedge clk) begin
    if (m_wb_cyc_o && m_wb_stb_o && !(m_wb_ack_i || m_wb_err_i)) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (!m_wb_cyc_o) beat_idx <= 0;
    else if (m_wb_stb_o && (m_wb_ack_i || m_wb_err_i)) beat_idx <= beat_idx + 1;
    if (rx_fifo_rd_o) begin
      rx_dat  <= rx_mem[rx_pops % 64];
      rx_pops <= rx_pops + 1;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_wb_cyc_o) cyc_cnt++;
      if (rx_fifo_rd_o) rd_cnt++;
      if (done_o) begin
        done_cnt++;
        n_tests++;
        if (busy_o !== 1'b0) begin
          n_fail++;
          $display("FAIL done_busy busy=%b required 0", busy_o);
        end
      end
      if (err_o) err_cnt++;
      if (m_wb_cyc_o && m_wb_stb_o && (m_wb_ack_i || m_wb_err_i)) begin
        n_tests++;
        if (exp_adr_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected adr=%h we=%b", m_wb_adr_o, m_wb_we_o);
        end else begin
          mon_e = exp_adr_q.pop_front();
          if ({m_wb_we_o, m_wb_adr_o} !== mon_e || m_wb_sel_o !== 4'hF) begin
            n_fail++;
            $display("FAIL beat_adr we/adr=%b/%h sel=%h required %b/%h sel=f",
                     m_wb_we_o, m_wb_adr_o, m_wb_sel_o, mon_e[32], mon_e[31:0]);
          end
          if (m_wb_we_o) begin
            n_tests++;
            mon_d = (exp_wdat_q.size() != 0) ? exp_wdat_q.pop_front() : 32'hxxxx_xxxx;
            if (m_wb_dat_o !== mon_d) begin
              n_fail++;
              $display("FAIL beat_wdat dat=%h required %h", m_wb_dat_o, mon_d);
            end
          end
        end
      end
      if (tx_fifo_we_o) begin
        n_tests++;
        if (exp_tx_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected dat=%h", tx_fifo_dat_o);
        end else begin
          mon_d = exp_tx_q.pop_front();
          if (tx_fifo_dat_o !== mon_d) begin
            n_fail++;
            $display("FAIL tx_dat dat=%h required %h", tx_fifo_dat_o, mon_d);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic dir, input logic [31:0] addr, input int len);
    dir_i   = dir;
    addr_i  = addr;
    len_i   = len[LEN_W-1:0];
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic push_read(input logic [31:0] addr, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = (addr & ~32'h3) + 32'(4 * i);
      exp_adr_q.push_back({1'b0, a});
      exp_tx_q.push_back(mem_f(a));
    end
  endtask

  task automatic wait_end(input string name, output logic cyc_at_end);
    int k;
    cyc_at_end = 1'bx;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_o || err_o) break;
    end
    if (k == 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout no done/err within 300 cycles", name);
    end else begin
      cyc_at_end = m_wb_cyc_o;
    end
    tick();
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_adr_q.size() != 0 || exp_tx_q.size() != 0 || exp_wdat_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained left adr=%0d tx=%0d wdat=%0d required 0/0/0", name,
               exp_adr_q.size(), exp_tx_q.size(), exp_wdat_q.size());
    end
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) tick();
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required 0", all_out);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (all_out !== '0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_idle got %h state=%0d required 0 state=0", all_out, dbg_state);
    end
  endtask

  task automatic test_read();
    int d0;
    logic c;
    d0 = done_cnt;
    wait_states = 0;
    push_read(32'h0000_1000, 4);
    start_xfer(1'b0, 32'h0000_1000, 4);
    n_tests++;
    if ({m_wb_cyc_o, m_wb_stb_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL read_first_stb cyc/stb=%b required 11", {m_wb_cyc_o, m_wb_stb_o});
    end
    wait_end("read", c);
    n_tests++;
    if (done_cnt != d0 + 1 || words_o !== 9'd4) begin
      n_fail++;
      $display("FAIL read_done done=%0d words=%0d required 1/4", done_cnt - d0, words_o);
    end
    check_drained("read");
  endtask

  task automatic test_write();
    logic [31:0] wd [3];
    int d0, r0;
    logic c;
    wd[0] = 32'hAAAA_0001; wd[1] = 32'hBBBB_0002; wd[2] = 32'hCCCC_0003;
    d0 = done_cnt;
    r0 = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      rx_mem[(rx_pushes + i) % 64] = wd[i];
      exp_adr_q.push_back({1'b1, 32'h0000_2000 + 32'(4 * i)});
      exp_wdat_q.push_back(wd[i]);
    end
    rx_pushes = rx_pushes + 3;
    start_xfer(1'b1, 32'h0000_2002, 3);
    n_tests++;
    if (rx_fifo_rd_o !== 1'b1 || m_wb_stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL write_pop rd=%b stb=%b required 1/0", rx_fifo_rd_o, m_wb_stb_o);
    end
    tick();
    tick();
    n_tests++;
    if (m_wb_stb_o !== 1'b1 || m_wb_we_o !== 1'b1) begin
      n_fail++;
      $display("FAIL write_stb_lat stb=%b we=%b required 1/1", m_wb_stb_o, m_wb_we_o);
    end
    wait_end("write", c);
    n_tests++;
    if (rd_cnt != r0 + 3 || done_cnt != d0 + 1 || words_o !== 9'd3 || !rx_fifo_empty_i) begin
      n_fail++;
      $display("FAIL write_done rd=%0d done=%0d words=%0d required 3/1/3",
               rd_cnt - r0, done_cnt - d0, words_o);
    end
    check_drained("write");
  endtask

  task automatic test_full_stall();
    int d0, bad, k;
    logic c;
    d0 = done_cnt;
    bad = 0;
    wait_states = 0;
    push_read(32'h0000_3000, 2);
    start_xfer(1'b0, 32'h0000_3000, 2);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx_fifo_we_o) break;
    end
    tick();
    tx_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_wb_stb_o || dbg_state != ST_WAIT) bad++;
    end
    tick();
    tx_full = 1'b0;
    n_tests++;
    if (bad != 0 || k == 50) begin
      n_fail++;
      $display("FAIL stall_stb stall_violations=%0d we_seen=%0d required 0/1", bad, k < 50);
    end
    wait_end("stall", c);
    n_tests++;
    if (done_cnt != d0 + 1 || words_o !== 9'd2) begin
      n_fail++;
      $display("FAIL stall_done done=%0d words=%0d required 1/2", done_cnt - d0, words_o);
    end
    check_drained("stall");
  endtask

  task automatic test_err();
    int d0, e0;
    logic c;
    d0 = done_cnt;
    e0 = err_cnt;
    wait_states = 0;
    err_beat = 1;
    exp_adr_q.push_back({1'b0, 32'h0000_7000});
    exp_adr_q.push_back({1'b0, 32'h0000_7004});
    exp_tx_q.push_back(mem_f(32'h0000_7000));
    start_xfer(1'b0, 32'h0000_7000, 5);
    wait_end("err", c);
    err_beat = -1;
    n_tests++;
    if (err_cnt != e0 + 1 || done_cnt != d0 || c !== 1'b0 || words_o !== 9'd1) begin
      n_fail++;
      $display("FAIL err_beat err=%0d done=%0d cyc=%b words=%0d required 1/0/0/1",
               err_cnt - e0, done_cnt - d0, c, words_o);
    end
    check_drained("err");
  endtask

  task automatic test_zero_len_wrap();
    int c0, d0;
    logic c;
    c0 = cyc_cnt;
    start_xfer(1'b0, 32'h0000_4000, 0);
    n_tests++;
    if ({done_o, busy_o, m_wb_cyc_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL zero_done done/busy/cyc=%b required 100", {done_o, busy_o, m_wb_cyc_o});
    end
    tick();
    n_tests++;
    if (done_o !== 1'b0 || cyc_cnt != c0 || words_o !== 9'd0) begin
      n_fail++;
      $display("FAIL zero_after done=%b cyc_cycles=%0d words=%0d required 0/0/0",
               done_o, cyc_cnt - c0, words_o);
    end
    d0 = done_cnt;
    push_read(32'hFFFF_FFFC, 2);
    start_xfer(1'b0, 32'hFFFF_FFFC, 2);
    wait_end("wrap", c);
    n_tests++;
    if (done_cnt != d0 + 1 || words_o !== 9'd2) begin
      n_fail++;
      $display("FAIL wrap_done done=%0d words=%0d required 1/2", done_cnt - d0, words_o);
    end
    check_drained("wrap");
  endtask

  task automatic test_abort();
    int d0, e0, k;
    d0 = done_cnt;
    e0 = err_cnt;
    wait_states = 5;
    push_read(32'h0000_5000, 1);
    start_xfer(1'b0, 32'h0000_5000, 3);
    abort_i = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    tick();
    abort_i = 1'b0;
    wait_states = 0;
    n_tests++;
    if (k == 50 || done_cnt != d0 || err_cnt != e0 || words_o !== 9'd1 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL abort_end idle_seen=%0d done=%0d err=%0d words=%0d required 1/0/0/1",
               k < 50, done_cnt - d0, err_cnt - e0, words_o);
    end
    check_drained("abort");
  endtask

  task automatic test_reset_mid();
    wait_states = 3;
    push_read(32'h0000_6000, 4);
    start_xfer(1'b0, 32'h0000_6000, 4);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (all_out !== '0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_mid got %h state=%0d required 0 state=0", all_out, dbg_state);
    end
    exp_adr_q.delete();
    exp_tx_q.delete();
    tick();
    rst_n = 1'b1;
    wait_states = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_full_stall();
    test_err();
    test_zero_len_wrap();
    test_abort();
    test_reset_mid();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
